// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm sequencer slice.
package alarm_pkg;

  localparam int unsigned TIME_W = 7;

  localparam int unsigned RING_SEC_DEFAULT   = 60;
  localparam int unsigned SNOOZE_SEC_DEFAULT = 300;
  localparam int unsigned MAX_SNOOZE_DEFAULT = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2
  } alarm_state_e;

  // One timer serves both intervals, so size it for the longer one.
  function automatic int unsigned timer_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ct_down_ld.sv
// Loadable down-counter that holds at zero; load has priority over count.
module ct_down_ld #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [Width-1:0] ld_val,
  input  logic             en,
  output logic [Width-1:0] ct_out,
  output logic             zero
);

  logic [Width-1:0] ct_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ct_q <= '0;
    end else if (ld) begin
      ct_q <= ld_val;
    end else if (en && (ct_q != '0)) begin
      ct_q <= ct_q - Width'(1);
    end
  end

  assign ct_out = ct_q;
  assign zero   = (ct_q == '0);

endmodule

// File: rtl/alarm_seq.sv
// Alarm sequencer: ring / snooze / dismiss with timed auto-off and bounded snoozes.
// Define ALARM_BEEP_EN for a 1-on/1-off beep while ringing instead of a steady tone.
module alarm_seq
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = RING_SEC_DEFAULT,
  parameter int unsigned SNOOZE_SEC = SNOOZE_SEC_DEFAULT,
  parameter int unsigned MAX_SNOOZE = MAX_SNOOZE_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [TIME_W-1:0]                  tsec,
  input  logic [TIME_W-1:0]                  tmin,
  input  logic [TIME_W-1:0]                  thrs,
  input  logic [TIME_W-1:0]                  amin,
  input  logic [TIME_W-1:0]                  ahrs,
  input  logic                               alarm_on,
  input  logic                               snooze,
  input  logic                               dismiss,
  output logic                               buzz,
  output logic                               snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]    snooze_cnt,
  output logic                               missed
);

  localparam int unsigned CntW   = $clog2(MAX_SNOOZE + 1);
  localparam int unsigned TimerW = timer_width(RING_SEC, SNOOZE_SEC);

  alarm_state_e        state_q, state_d;
  logic [CntW-1:0]     snooze_cnt_q, snooze_cnt_d;
  logic                missed_q, missed_d;

  logic                tmr_ld;
  logic [TimerW-1:0]   tmr_ld_val;
  logic                tmr_en;
  logic [TimerW-1:0]   tmr_ct;
  logic                tmr_zero;

  logic trigger;
  assign trigger = alarm_on && (tsec == '0) && (tmin == amin) && (thrs == ahrs);

  ct_down_ld #(
    .Width (TimerW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .ld     (tmr_ld),
    .ld_val (tmr_ld_val),
    .en     (tmr_en),
    .ct_out (tmr_ct),
    .zero   (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      snooze_cnt_q <= '0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    tmr_ld       = 1'b0;
    tmr_ld_val   = '0;
    tmr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dismiss) missed_d = 1'b0;
        if (trigger) begin
          state_d    = StRinging;
          tmr_ld     = 1'b1;
          tmr_ld_val = TimerW'(RING_SEC - 1);
        end
      end

      StRinging: begin
        // Priority: leave/dismiss, then snooze, then timeout.
        if (!alarm_on || dismiss) begin
          state_d      = StIdle;
          snooze_cnt_d = '0;
          if (dismiss) missed_d = 1'b0;
        end else if (snooze && (snooze_cnt_q < CntW'(MAX_SNOOZE))) begin
          state_d      = StSnooze;
          tmr_ld       = 1'b1;
          tmr_ld_val   = TimerW'(SNOOZE_SEC - 1);
          snooze_cnt_d = snooze_cnt_q + CntW'(1);
        end else if (tmr_zero) begin
          state_d      = StIdle;
          missed_d     = 1'b1;
          snooze_cnt_d = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end

      StSnooze: begin
        if (!alarm_on || dismiss) begin
          state_d      = StIdle;
          snooze_cnt_d = '0;
          if (dismiss) missed_d = 1'b0;
        end else if (tmr_zero) begin
          state_d    = StRinging;
          tmr_ld     = 1'b1;
          tmr_ld_val = TimerW'(RING_SEC - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef ALARM_BEEP_EN
  logic phase_q;

  // Held at 0 outside RINGING so every ring starts with the buzzer on.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else if (state_q == StRinging) begin
      phase_q <= ~phase_q;
    end else begin
      phase_q <= 1'b0;
    end
  end

  assign buzz = (state_q == StRinging) && !phase_q;
`else
  assign buzz = (state_q == StRinging);
`endif

  assign snoozing   = (state_q == StSnooze);
  assign snooze_cnt = snooze_cnt_q;
  assign missed     = missed_q;

endmodule
